// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Purpose:
//   Read-side output stage of the asynchronous FIFO (read clock domain). It owns
//   the FIFO read request and converts the rd_en/empty + one-cycle-latency
//   rd_data memory interface into a valid/ready stream with first-word-fall-
//   through behaviour. A 3-entry skid buffer sustains one word per cycle while
//   keeping m_ready out of the combinational path to rd_en. A synchronous flush
//   discards buffered and in-flight words.
//
// Ports:
//   rd_clk   in   read-domain clock, rising edge
//   rd_rst   in   asynchronous active-low reset
//   empty    in   FIFO empty flag (registered upstream)
//   rd_data  in   memory read data, valid the cycle after an accepted read
//   rd_en    out  read request to pointer logic and memory
//   flush    in   synchronous discard of buffered and in-flight words
//   m_valid  out  head word available
//   m_ready  in   consumer accepts the head word
//   m_data   out  head word
//   m_count  out  words held in the buffer, 0..3
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DATASIZE = 8
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                empty,
  input  logic [DATASIZE-1:0] rd_data,
  output logic                rd_en,
  input  logic                flush,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data,
  output logic [1:0]          m_count
);

  logic [1:0] count_q, count_d;
  logic [1:0] head_q, head_d;
  logic [1:0] tail_q, tail_d;
  logic       pend_q, pend_d;

  logic       push;
  logic       pop;
  logic [2:0] occupancy;

  logic [DATASIZE-1:0] entry_w [3];

  // Pointers run 0,1,2,0,... over the three entries.
  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already stored plus the word still in flight from the memory.
  // Reading only when this is below 3 guarantees a free slot for every
  // arriving word, so m_ready never needs to reach rd_en.
  always_comb begin
    occupancy = {1'b0, count_q} + {2'b00, pend_q};
    rd_en     = rd_rst && !empty && !flush && (occupancy < 3'd3);
  end

  always_comb begin
    m_valid = (count_q != 2'd0);
    m_count = count_q;
    pop     = m_valid && m_ready;
    // An in-flight word arriving during flush is dropped.
    push    = pend_q && !flush;
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    pend_d  = 1'b0;
    if (flush) begin
      count_d = 2'd0;
      head_d  = 2'd0;
      tail_d  = 2'd0;
      pend_d  = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        head_d = wrap_inc(head_q);
      end
      if (push) begin
        tail_d = wrap_inc(tail_q);
      end
      // rd_en already includes !empty, so this is exactly an accepted read.
      pend_d = rd_en;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      count_q <= 2'd0;
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      pend_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      pend_q  <= pend_d;
    end
  end

  // Storage entries. Each is its own register so the head mux below reads
  // only flops and m_data is never X after reset.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_entry
      logic [DATASIZE-1:0] entry_q;

      always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
          entry_q <= '0;
        end else if (push && (tail_q == 2'(gi))) begin
          entry_q <= rd_data;
        end
      end

      assign entry_w[gi] = entry_q;
    end
  endgenerate

  always_comb begin
    case (head_q)
      2'd0:    m_data = entry_w[0];
      2'd1:    m_data = entry_w[1];
      default: m_data = entry_w[2];
    endcase
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Purpose:
//   Self-checking bench for fifo_rd_stream. An upstream FIFO (word array plus
//   read/write indices) feeds the DUT; a queue-based model of the stream
//   buffer predicts rd_en, m_valid, m_count and m_data every cycle. Directed
//   phases pin the model with literal expectations; a random phase follows.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic       empty;
  logic [7:0] rd_data = 8'h00;
  logic       rd_en;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] m_count;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(.DATASIZE(8)) dut (
    .rd_clk  (rd_clk),
    .rd_rst  (rd_rst),
    .empty   (empty),
    .rd_data (rd_data),
    .rd_en   (rd_en),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count)
  );

  // Upstream FIFO: words written at mem[wptr], read at mem[rptr].
  logic [7:0] mem [0:1023];
  int         rptr = 0;
  int         wptr = 0;
  assign empty = (rptr == wptr);

  // Reference model: words held in the buffer and the word in flight.
  logic [7:0] mq[$];
  bit         mpend = 1'b0;
  logic [7:0] mword = 8'h00;
  bit         m_room, m_acc;
  logic [7:0] m_w;
  logic [7:0] dut_out[$];   // words the DUT actually handed over

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic write_word(input logic [7:0] w);
    mem[wptr] = w;
    wptr = wptr + 1;
  endtask

  // Model update plus upstream memory behaviour, at every clock edge.
  always @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      mq.delete();
      mpend = 1'b0;
    end else begin
      m_room = (mq.size() + int'(mpend)) < 3;
      m_acc  = !empty && !flush && m_room;
      m_w    = mem[rptr];
      if (m_valid && m_ready) dut_out.push_back(m_data);
      if (flush) begin
        mq.delete();
        mpend = 1'b0;
      end else begin
        if (m_ready && mq.size() != 0) void'(mq.pop_front());
        if (mpend) mq.push_back(mword);
        mpend = m_acc;
        mword = m_w;
      end
      if (rd_en && !empty) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + 1;
      end else begin
        rd_data <= 8'($urandom);
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge rd_clk) begin
    if (rd_rst === 1'b1) begin
      chk("rd_en", rd_en, !empty && !flush && ((mq.size() + int'(mpend)) < 3));
      chk("m_valid", m_valid, mq.size() != 0);
      chk("m_count", m_count, mq.size());
      if (mq.size() != 0) chk("m_data", m_data, mq[0]);
      chk("m_data_xfree", !$isunknown(m_data), 1'b1);
      chk("invariant", (int'(dut.count_q) + int'(dut.pend_q)) <= 3, 1'b1);
      chk("push_when_full", !(dut.pend_q && !flush && dut.count_q == 2'd3), 1'b1);
    end else begin
      chk("rst_rd_en", rd_en, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_count", m_count, 2'd0);
      chk("rst_m_data", m_data, 8'h00);
    end
  end

  int valid_cycles;
  int maxc;
  int r0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rd_rst  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;

    // Reset with data waiting upstream.
    for (int i = 1; i <= 16; i++) write_word(8'(i));
    repeat (3) tick();
    #1;
    chk("reset_rd_en", rd_en, 1'b0);
    chk("reset_m_valid", m_valid, 1'b0);
    chk("reset_m_data", m_data, 8'h00);
    chk("reset_m_count", m_count, 2'd0);

    // Streaming with m_ready held high.
    dut_out.delete();
    m_ready = 1'b1;
    rd_rst  = 1'b1;
    #1;
    chk("release_rd_en", rd_en, 1'b1);
    tick();
    chk("latency_e0_valid", m_valid, 1'b0);
    tick();
    chk("latency_e1_valid", m_valid, 1'b1);
    chk("first_word", m_data, 8'h01);
    valid_cycles = 1;
    maxc = int'(m_count);
    repeat (15) begin
      tick();
      valid_cycles += int'(m_valid);
      if (int'(m_count) > maxc) maxc = int'(m_count);
    end
    chk("stream_no_bubbles", valid_cycles, 16);
    chk("stream_max_count", maxc, 1);
    repeat (4) tick();
    chk("stream_size", dut_out.size(), 16);
    for (int i = 0; i < 16 && i < dut_out.size(); i++)
      chk("stream_word", dut_out[i], 8'(i + 1));

    // Backpressure, then resume.
    m_ready = 1'b0;
    dut_out.delete();
    r0 = rptr;
    for (int i = 1; i <= 8; i++) write_word(8'(i));
    repeat (6) tick();
    chk("bp_reads", rptr - r0, 3);
    chk("bp_count", m_count, 2'd3);
    chk("bp_rd_en", rd_en, 1'b0);
    chk("bp_head", m_data, 8'h01);
    repeat (3) tick();
    chk("bp_head_stable", m_data, 8'h01);
    m_ready = 1'b1;
    #1;
    chk("resume_rd_en_low", rd_en, 1'b0);
    tick();
    chk("resume_rd_en_high", rd_en, 1'b1);
    repeat (12) tick();
    chk("bp_size", dut_out.size(), 8);
    for (int i = 0; i < 8 && i < dut_out.size(); i++)
      chk("bp_word", dut_out[i], 8'(i + 1));

    // Single word, random ready.
    m_ready = 1'b0;
    dut_out.delete();
    r0 = rptr;
    write_word(8'hA5);
    repeat (30) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready = 1'b1;
    repeat (4) tick();
    chk("single_size", dut_out.size(), 1);
    if (dut_out.size() != 0) chk("single_word", dut_out[0], 8'hA5);
    chk("single_reads", rptr - r0, 1);

    // Flush with two words buffered and one in flight.
    m_ready = 1'b0;
    dut_out.delete();
    for (int i = 0; i < 10; i++) write_word(8'h30 + 8'(i));
    repeat (3) tick();
    chk("pre_flush_count", m_count, 2'd2);
    m_ready = 1'b1;
    flush   = 1'b1;
    #1;
    chk("flush_rd_en", rd_en, 1'b0);
    tick();
    flush = 1'b0;
    chk("post_flush_count", m_count, 2'd0);
    chk("post_flush_valid", m_valid, 1'b0);
    repeat (12) tick();
    chk("flush_size", dut_out.size(), 8);
    if (dut_out.size() >= 8) begin
      chk("flush_delivered", dut_out[0], 8'h30);
      chk("flush_next", dut_out[1], 8'h33);
      chk("flush_last", dut_out[7], 8'h39);
    end

    // Asynchronous reset with a full buffer.
    m_ready = 1'b0;
    dut_out.delete();
    for (int i = 0; i < 6; i++) write_word(8'h50 + 8'(i));
    repeat (5) tick();
    chk("pre_rst_count", m_count, 2'd3);
    #1;
    rd_rst = 1'b0;
    #1;
    chk("async_rst_valid", m_valid, 1'b0);
    chk("async_rst_count", m_count, 2'd0);
    chk("async_rst_data", m_data, 8'h00);
    chk("async_rst_rd_en", rd_en, 1'b0);
    tick();
    tick();
    rd_rst  = 1'b1;
    m_ready = 1'b1;
    repeat (10) tick();
    chk("after_rst_size", dut_out.size(), 3);
    if (dut_out.size() >= 3) begin
      chk("after_rst_w0", dut_out[0], 8'h53);
      chk("after_rst_w2", dut_out[2], 8'h55);
    end

    // Random traffic, checked cycle by cycle against the model.
    repeat (800) begin
      if ($urandom_range(0, 3) == 0 && wptr < 1000) begin
        write_word(8'($urandom));
        if ($urandom_range(0, 1) == 1) write_word(8'($urandom));
      end
      m_ready = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 24) == 0);
      tick();
    end
    flush   = 1'b0;
    m_ready = 1'b1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
